// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_arb_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 1024;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter.
// master = arbiter view, slave = requesters plus memory controller view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [N_REQ-1:0]             req_avail;
  logic [N_REQ-1:0]             req_r_en;
  logic [N_REQ-1:0]             req_w_en;
  logic [N_REQ-1:0]             req_write_through;
  logic [N_REQ-1:0][ADDR_W-1:0] req_ptr;
  logic [N_REQ-1:0][DATA_W-1:0] req_data_store;
  logic [N_REQ-1:0]             req_done;
  logic                         req_err;
  logic [DATA_W-1:0]            req_data_load;

  logic                         mem_r_en;
  logic                         mem_w_en;
  logic                         mem_write_through;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic                         mem_done;
  logic [DATA_W-1:0]            mem_rdata;

  modport master (
    input  req_avail, req_r_en, req_w_en, req_write_through, req_ptr, req_data_store,
    output req_done, req_err, req_data_load,
    output mem_r_en, mem_w_en, mem_write_through, mem_addr, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport slave (
    output req_avail, req_r_en, req_w_en, req_write_through, req_ptr, req_data_store,
    input  req_done, req_err, req_data_load,
    input  mem_r_en, mem_w_en, mem_write_through, mem_addr, mem_wdata,
    output mem_done, mem_rdata
  );

endinterface

// File: rtl/mem_arb_rr_select.sv
// Rotate-priority encoder: first set bit of cand at or after rr_ptr, wrapping.
module mem_arb_rr_select
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  // slot[k] is the requester k positions after rr_ptr; hit[k] marks it as a candidate.
  logic [IDX_W-1:0] slot [N_REQ];
  logic [N_REQ-1:0] hit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign slot[gi] = IDX_W'((int'(rr_ptr) + gi) % N_REQ);
    assign hit[gi]  = cand[slot[gi]];
  end

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        grant = slot[k];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serializing N_REQ memory handles onto one memory port.
// Optional BUSY timeout abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic                clk,
  input logic                rst_l,
  mem_port_arbiter_if.master bus
);

  localparam int IDX_W = idx_width(N_REQ);

  mem_arb_state_t    state_reg, state_next;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]  grant_reg, grant_next;
  logic [N_REQ-1:0]  done_reg, done_next;
  logic              r_en_reg, r_en_next;
  logic              w_en_reg, w_en_next;
  logic              wt_reg, wt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;

  logic [N_REQ-1:0]  cand;
  logic [IDX_W-1:0]  sel_grant;
  logic              sel_valid;

  assign cand = bus.req_avail & (bus.req_r_en | bus.req_w_en);

  mem_arb_rr_select #(.N_REQ(N_REQ)) u_rr_select (
    .cand   (cand),
    .rr_ptr (rr_ptr_reg),
    .grant  (sel_grant),
    .valid  (sel_valid)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             timeout_hit;

  // Counter holds zero outside BUSY, so every BUSY entry starts from zero.
  assign timeout_hit = (cnt_reg + CNT_W'(1)) == CNT_W'(TIMEOUT);

  always_comb begin
    cnt_next = '0;
    if (state_reg == BUSY) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  assign bus.req_err = err_reg;
`else
  wire unused_timeout = (TIMEOUT == 0);

  assign bus.req_err = 1'b0;
`endif

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    done_next   = '0;
    r_en_next   = r_en_reg;
    w_en_next   = w_en_reg;
    wt_next     = wt_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
`ifdef MEM_ARB_TIMEOUT_EN
    err_next    = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          // A request with both enables set is treated as a write.
          grant_next = sel_grant;
          w_en_next  = bus.req_w_en[sel_grant];
          r_en_next  = !bus.req_w_en[sel_grant];
          wt_next    = bus.req_write_through[sel_grant];
          addr_next  = bus.req_ptr[sel_grant];
          wdata_next = bus.req_data_store[sel_grant];
          state_next = BUSY;
        end
      end

      BUSY: begin
        if (bus.mem_done) begin
          if (r_en_reg) begin
            rdata_next = bus.mem_rdata;
          end
          r_en_next            = 1'b0;
          w_en_next            = 1'b0;
          done_next[grant_reg] = 1'b1;
          state_next           = RESP;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          r_en_next            = 1'b0;
          w_en_next            = 1'b0;
          done_next[grant_reg] = 1'b1;
          err_next             = 1'b1;
          state_next           = RESP;
        end
`endif
      end

      RESP: begin
        rr_ptr_next = (grant_reg == IDX_W'(N_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
        state_next  = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      grant_reg  <= '0;
      done_reg   <= '0;
      r_en_reg   <= 1'b0;
      w_en_reg   <= 1'b0;
      wt_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      done_reg   <= done_next;
      r_en_reg   <= r_en_next;
      w_en_reg   <= w_en_next;
      wt_reg     <= wt_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
    end
  end

  assign bus.req_done          = done_reg;
  assign bus.req_data_load     = rdata_reg;
  assign bus.mem_r_en          = r_en_reg;
  assign bus.mem_w_en          = w_en_reg;
  assign bus.mem_write_through = wt_reg;
  assign bus.mem_addr          = addr_reg;
  assign bus.mem_wdata         = wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; define MEM_ARB_TIMEOUT_EN to add the timeout case.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst_l;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [3:0]  set_mask;
    logic        r;
    logic        w;
    logic        wt;
    logic [31:0] ptr_base;
    logic [31:0] data_base;
    int          lat;
    logic [31:0] rdata;
    int          exp_grant;
    logic        exp_r;
    logic        exp_w;
    logic        exp_wt;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(string name, logic [3:0] m, logic r, logic w, logic wt,
                              logic [31:0] pb, logic [31:0] db, int lat, logic [31:0] rd,
                              int g, logic er, logic ew, logic ewt,
                              logic [31:0] ea, logic [31:0] ed, logic [31:0] el);
    vec_t v;
    v.name = name; v.set_mask = m; v.r = r; v.w = w; v.wt = wt;
    v.ptr_base = pb; v.data_base = db; v.lat = lat; v.rdata = rd;
    v.exp_grant = g; v.exp_r = er; v.exp_w = ew; v.exp_wt = ewt;
    v.exp_addr = ea; v.exp_wdata = ed; v.exp_load = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {bus.req_done, bus.req_err, bus.mem_r_en, bus.mem_w_en,
                           bus.mem_write_through}, 0);
    check({name, "_addr"}, bus.mem_addr, 0);
    check({name, "_wdata"}, bus.mem_wdata, 0);
    check({name, "_load"}, bus.req_data_load, 0);
  endtask

  // Requester i raises a request; ptr/data are derived from the bases.
  task automatic raise(input int i, input logic r, input logic w, input logic wt,
                       input logic [31:0] pb, input logic [31:0] db);
    bus.req_avail[i]         = 1'b1;
    bus.req_r_en[i]          = r;
    bus.req_w_en[i]          = w;
    bus.req_write_through[i] = wt;
    bus.req_ptr[i]           = pb + 32'(4 * i);
    bus.req_data_store[i]    = db + 32'(i);
  endtask

  task automatic wait_en(input string name);
    int n;
    n = 0;
    while (!(bus.mem_r_en || bus.mem_w_en) && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({name, "_grant_seen"}, bus.mem_r_en | bus.mem_w_en, 1);
  endtask

  // Answers the memory access after lat BUSY cycles and checks the done pulse.
  task automatic complete(input string name, input int lat, input logic [31:0] rdata,
                          input int exp_grant, input logic [31:0] exp_load);
    repeat (lat - 1) @(negedge clk);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    check({name, "_done"}, bus.req_done, 64'(1) << exp_grant);
    check({name, "_load"}, bus.req_data_load, exp_load);
    check({name, "_en_drop"}, {bus.mem_r_en, bus.mem_w_en}, 0);
    check({name, "_err"}, bus.req_err, 0);
    $display("[TB] %s: done=%b load=0x%08h", name, bus.req_done, bus.req_data_load);
    for (int i = 0; i < N; i++) begin
      if (bus.req_done[i]) begin
        bus.req_avail[i] = 1'b0;
        bus.req_r_en[i]  = 1'b0;
        bus.req_w_en[i]  = 1'b0;
      end
    end
    @(negedge clk);
    check({name, "_done_1cyc"}, bus.req_done, 0);
  endtask

  initial begin
    bit any_en;
    int busy_cycles;

    rst_l                 = 1'b0;
    bus.req_avail         = '0;
    bus.req_r_en          = '0;
    bus.req_w_en          = '0;
    bus.req_write_through = '0;
    bus.req_ptr           = '0;
    bus.req_data_store    = '0;
    bus.mem_done          = 1'b0;
    bus.mem_rdata         = '0;

    //          name         mask     r  w  wt ptr_base  data_base lat rdata          g  er ew ewt addr      wdata     load
    vecs[0] = mk("wr4_g0",   4'b1111, 0, 1, 1, 32'h200, 32'h1000, 1, 32'hBAD0BAD0, 0, 0, 1, 1, 32'h200, 32'h1000, 32'h0);
    vecs[1] = mk("wr4_g1",   4'b0000, 0, 0, 0, 32'h0,   32'h0,    1, 32'hBAD0BAD0, 1, 0, 1, 1, 32'h204, 32'h1001, 32'h0);
    vecs[2] = mk("wr4_g2",   4'b0000, 0, 0, 0, 32'h0,   32'h0,    1, 32'hBAD0BAD0, 2, 0, 1, 1, 32'h208, 32'h1002, 32'h0);
    vecs[3] = mk("wr4_g3",   4'b0000, 0, 0, 0, 32'h0,   32'h0,    1, 32'hBAD0BAD0, 3, 0, 1, 1, 32'h20C, 32'h1003, 32'h0);
    vecs[4] = mk("rr_0_3a",  4'b1001, 0, 1, 0, 32'h300, 32'h2000, 2, 32'hBAD0BAD0, 0, 0, 1, 0, 32'h300, 32'h2000, 32'h0);
    vecs[5] = mk("rr_0_3b",  4'b0000, 0, 0, 0, 32'h0,   32'h0,    1, 32'hBAD0BAD0, 3, 0, 1, 0, 32'h30C, 32'h2003, 32'h0);
    vecs[6] = mk("rd_single",4'b0100, 1, 0, 0, 32'h38,  32'h0,    3, 32'hDEADBEEF, 2, 1, 0, 0, 32'h40,  32'h2,    32'hDEADBEEF);
    vecs[7] = mk("rr_ptr3",  4'b1001, 1, 0, 0, 32'h500, 32'h0,    1, 32'h11111111, 3, 1, 0, 0, 32'h50C, 32'h3,    32'h11111111);
    vecs[8] = mk("rd_g0",    4'b0000, 0, 0, 0, 32'h0,   32'h0,    1, 32'h22222222, 0, 1, 0, 0, 32'h500, 32'h0,    32'h22222222);
    vecs[9] = mk("rw_confl", 4'b0010, 1, 1, 0, 32'h600, 32'h4,    2, 32'hBAD0BAD0, 1, 0, 1, 0, 32'h604, 32'h5,    32'h22222222);

    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    rst_l = 1'b1;
    @(negedge clk);
    check_all_zero("reset_idle");

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) begin
        if (vecs[v].set_mask[i]) begin
          raise(i, vecs[v].r, vecs[v].w, vecs[v].wt, vecs[v].ptr_base, vecs[v].data_base);
        end
      end
      wait_en(vecs[v].name);
      check({vecs[v].name, "_r_en"}, bus.mem_r_en, vecs[v].exp_r);
      check({vecs[v].name, "_w_en"}, bus.mem_w_en, vecs[v].exp_w);
      check({vecs[v].name, "_wt"}, bus.mem_write_through, vecs[v].exp_wt);
      check({vecs[v].name, "_addr"}, bus.mem_addr, vecs[v].exp_addr);
      check({vecs[v].name, "_wdata"}, bus.mem_wdata, vecs[v].exp_wdata);
      complete(vecs[v].name, vecs[v].lat, vecs[v].rdata, vecs[v].exp_grant, vecs[v].exp_load);
    end

    // Reset while requester 3 is in flight; afterwards the pointer is back at 0.
    raise(1, 1'b0, 1'b1, 1'b0, 32'h700, 32'h70);
    raise(3, 1'b0, 1'b1, 1'b0, 32'h700, 32'h70);
    wait_en("rst_pre");
    check("rst_pre_addr", bus.mem_addr, 32'h70C);
    #2 rst_l = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst_l = 1'b1;
    wait_en("rst_post1");
    check("rst_post1_addr", bus.mem_addr, 32'h704);
    check("rst_post1_wdata", bus.mem_wdata, 32'h71);
    complete("rst_post1", 1, 32'hBAD0BAD0, 1, 32'h0);
    wait_en("rst_post3");
    check("rst_post3_addr", bus.mem_addr, 32'h70C);
    complete("rst_post3", 1, 32'hBAD0BAD0, 3, 32'h0);

    // Requester 0 withdraws and changes its inputs mid-flight.
    raise(0, 1'b1, 1'b0, 1'b0, 32'h800, 32'h0);
    wait_en("drop");
    bus.req_avail[0] = 1'b0;
    bus.req_r_en[0]  = 1'b0;
    bus.req_ptr[0]   = 32'h900;
    @(negedge clk);
    check("drop_addr_stable", bus.mem_addr, 32'h800);
    check("drop_r_en_held", bus.mem_r_en, 1);
    complete("drop", 1, 32'hCAFE0000, 0, 32'hCAFE0000);
    any_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any_en |= bus.mem_r_en | bus.mem_w_en;
    end
    check("drop_no_regrant", any_en, 0);

    // avail without an enable is not a candidate; mem_done in IDLE is ignored.
    bus.req_avail[1] = 1'b1;
    bus.mem_done     = 1'b1;
    bus.mem_rdata    = 32'hFFFFFFFF;
    @(negedge clk);
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    any_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_en |= bus.mem_r_en | bus.mem_w_en | (|bus.req_done);
    end
    check("idle_no_grant", any_en, 0);
    check("idle_load_kept", bus.req_data_load, 32'hCAFE0000);
    $display("[TB] idle_ignore: load=0x%08h", bus.req_data_load);
    bus.req_avail[1] = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    raise(2, 1'b1, 1'b0, 1'b0, 32'h900, 32'h0);
    wait_en("tmo");
    busy_cycles = 0;
    while ((bus.mem_r_en || bus.mem_w_en) && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("tmo_busy_cycles", 64'(busy_cycles), 8);
    check("tmo_done", bus.req_done, 4'b0100);
    check("tmo_err", bus.req_err, 1);
    check("tmo_load_kept", bus.req_data_load, 32'hCAFE0000);
    $display("[TB] timeout: busy=%0d done=%b err=%b", busy_cycles, bus.req_done, bus.req_err);
    bus.req_avail[2] = 1'b0;
    bus.req_r_en[2]  = 1'b0;
    @(negedge clk);
    check("tmo_err_1cyc", {bus.req_done, bus.req_err}, 0);
`else
    busy_cycles = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
